mandel_pixel_writer: RTL and testbench
======================================

// Module: mandel_pixel_writer
// PURPOSE
// - Downstream of the Mandelbrot iteration engine. Accepts one result per pixel (iteration count + in-set flag).
// - Buffers results in a small FIFO, tracks the pixel coordinate, maps each result to a 2-bit colour, and
//   writes it into the video framebuffer write port (wx/wy/wd/we).
// - Optionally forwards each count byte to the UART transmitter.
// PARAMETERS
// - N_PIX_X     192  pixels per row (wx range 0..N_PIX_X-1)
// - N_PIX_Y     128  pixels per column (wy range 0..N_PIX_Y-1)
// - FIFO_DEPTH  4    result FIFO entries, power of 2, >=2
// PORTS
// - clk          in   1  system clock (24 MHz domain, same as framebuffer mem_clk)
// - rst          in   1  reset, asynchronous, active-high
// - frame_start  in   1  1-cycle pulse: begin new frame at (0,0)
// - res_valid    in   1  result available
// - res_ready    out  1  result accepted when res_valid&&res_ready at posedge
// - res_iter     in   8  iteration count
// - res_inset    in   1  1 = max iterations reached (in set)
// - wx           out  8  framebuffer write X
// - wy           out  7  framebuffer write Y
// - wd           out  2  framebuffer write colour
// - we           out  1  framebuffer write enable, 1 cycle per pixel
// - frame_done   out  1  1-cycle pulse after last pixel written
// - busy         out  1  high from frame_start until frame_done
// - tx_data      out  8  [ITER_TX_EN] byte to TX8
// - tx_start     out  1  [ITER_TX_EN] 1-cycle start pulse to TX8
// - tx_busy      in   1  [ITER_TX_EN] TX8 busy
// BEHAVIOUR
// - Reset (async): all outputs 0; FIFO empty; coordinate (0,0); FSM=IDLE.
// - Reset is honoured mid-frame: the frame is abandoned and no frame_done is issued.
// - FSM states and transitions:
//   - IDLE: res_ready=0. frame_start -> RUN.
//   - RUN: res_ready=!fifo_full. Pops the FIFO head when not empty (and TX idle under ITER_TX_EN).
//   - RUN -> DONE when the pop of pixel (N_PIX_X-1,N_PIX_Y-1) completes.
//   - DONE: lasts 1 cycle; frame_done=1; -> IDLE.
// - frame_start in any state: flush FIFO, clear coordinate, clear we, go to RUN. This takes priority over a
//   simultaneous push or pop, and the push is dropped.
// - Scan order is column-major: wy increments first.
//   - At wy==N_PIX_Y-1, wy<=0 and wx<=wx+1.
//   - At the last pixel, the coordinate wraps to (0,0).
// - Latency: a result pushed at edge N, into an empty FIFO, is popped at edge N+1. At edge N+1, registered
//   we/wx/wy/wd go valid for exactly 1 cycle.
// - Throughput: 1 pixel/clk. FIFO push and pop in the same cycle are both legal, including when full
//   (res_ready stays low when full) and when empty (no pop).
// - Colour map (registered):
//   - res_inset=1 -> wd=2'b00 (black).
//   - else iter[1:0]==00 -> 2'b11.
//   - else -> iter[1:0] (never 00 for outside pixels).
// - Results arriving in IDLE/DONE are not accepted (res_ready=0).
// CONFIGURATION
// - ITER_TX_EN defined: every popped result also sends tx_data=res_iter.
//   - Pop only when TX FSM is idle and tx_busy==0.
//   - tx_start is pulsed 1 cycle (same cycle as we).
//   - TX FSM then waits for tx_busy=1 (TX_ARM), then tx_busy=0 (TX_WAIT), before allowing the next pop.
//   - TX FSM idle resets on frame_start.
// - ITER_TX_EN undefined: tx_* ports absent; pop is gated only by FIFO empty.
// STRUCTURE
// - mandel_pkg: N_PIX_X/N_PIX_Y defaults, colour constants COL_BLACK=2'b00, COL_WRAP=2'b11, FSM state encoding.
// - Sub-module result_fifo (DEPTH, WIDTH=9): sync FIFO with full/empty, push/pop, flush input.
// - Top holds FSM, coordinate counters, colour map, TX sub-FSM.
// TESTING
// - Reset mid-frame (after 10 pixels) -> outputs 0, busy=0, no frame_done; next frame_start restarts at (0,0).
// - frame_start, then results iter=5,8,3 out / iter=100 inset ->
//   - we pulses at (0,0) wd=01, (0,1) wd=11, (0,2) wd=11, (0,3) wd=00.
//   - first we is exactly 1 cycle after the first accepted push.
// - Stream 128 results -> last at (0,127), next at (1,0). Full 192*128 frame -> one frame_done pulse after
//   (191,127), FSM back to IDLE, res_ready=0.
// - Backpressure (ITER_TX_EN, tx_busy held high) with res_valid stuck at 1 ->
//   - exactly FIFO_DEPTH accepted, res_ready=0, no data lost.
//   - after tx_busy drops, order is preserved.
// - frame_start while FIFO holds 3 entries, with a simultaneous push -> FIFO empty, push dropped,
//   next write at (0,0).
// - ITER_TX_EN: tx_busy modelled as 10 cycles high after tx_start -> one tx_start per pixel, tx_data==res_iter,
//   no tx_start while tx_busy=1.

Source files
------------

// File: rtl/mandel_pixel_writer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mandel_pixel_writer_pkg
// Description : Shared constants for the Mandelbrot pixel writer: frame
//               geometry defaults, colour codes, FSM state encodings and the
//               iteration-count to colour mapping.
// Revision    : 1.0  initial release
// ============================================================================
package mandel_pixel_writer_pkg;

  localparam int N_PIX_X_DEF = 192;
  localparam int N_PIX_Y_DEF = 128;

  localparam logic [1:0] COL_BLACK = 2'b00;
  localparam logic [1:0] COL_WRAP  = 2'b11;

  // Main frame FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // UART forwarding sub-FSM
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_ARM  = 2'd1;
  localparam logic [1:0] TX_WAIT = 2'd2;

  // In-set pixels are black; outside pixels never use code 00 so they stay
  // distinguishable from the set, hence 00 folds onto 11.
  function automatic logic [1:0] colour_map(input logic [7:0] iter, input logic inset);
    if (inset)
      return COL_BLACK;
    else if (iter[1:0] == 2'b00)
      return COL_WRAP;
    else
      return iter[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mandel_pixel_writer_if.sv
`default_nettype none
// ============================================================================
// Interface   : mandel_pixel_writer_if
// Description : Result handshake from the iteration engine plus the
//               framebuffer write port. master = environment side,
//               slave = pixel writer side.
// Revision    : 1.0  initial release
// ============================================================================
interface mandel_pixel_writer_if;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_iter;
  logic       res_inset;
  logic [7:0] wx;
  logic [6:0] wy;
  logic [1:0] wd;
  logic       we;

  modport master (
    output res_valid, res_iter, res_inset,
    input  res_ready, wx, wy, wd, we
  );

  modport slave (
    input  res_valid, res_iter, res_inset,
    output res_ready, wx, wy, wd, we
  );
endinterface
`default_nettype wire

// File: rtl/mandel_pixel_writer_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Small synchronous FIFO with full/empty flags and a flush
//               input that empties it in one cycle. DEPTH must be a power
//               of two and at least 2.
// Revision    : 1.0  initial release
// ============================================================================
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush overrides any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between pointers so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mandel_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pixel_writer
// Description : Buffers Mandelbrot results, walks the frame in column-major
//               order, maps each result to a 2-bit colour and writes it to
//               the framebuffer. Optional macro ITER_TX_EN also forwards
//               each iteration count to a UART transmitter.
// Revision    : 1.0  initial release
// ============================================================================
module mandel_pixel_writer
  import mandel_pixel_writer_pkg::*;
#(
  parameter int N_PIX_X    = N_PIX_X_DEF,
  parameter int N_PIX_Y    = N_PIX_Y_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             frame_start,
  output logic                  frame_done,
  output logic                  busy,
  mandel_pixel_writer_if.slave  pix
`ifdef ITER_TX_EN
  ,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  wire logic             tx_busy
`endif
);

  logic [1:0] state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] wx_q, wx_d;
  logic [6:0] wy_q, wy_d;
  logic [1:0] wd_q, wd_d;
  logic       we_q, we_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic [8:0] head;
  logic       res_ready;
  logic       push;
  logic       pop;
  logic       tx_ok;
  logic       last_pix;

  assign res_ready = (state_q == ST_RUN) && !fifo_full;
  // A push coinciding with frame_start belongs to the abandoned frame
  assign push      = pix.res_valid && res_ready && !frame_start;
  assign pop       = (state_q == ST_RUN) && !fifo_empty && tx_ok && !frame_start;
  assign last_pix  = (cx_q == 8'(N_PIX_X - 1)) && (cy_q == 7'(N_PIX_Y - 1));

  assign pix.res_ready = res_ready;
  assign pix.wx        = wx_q;
  assign pix.wy        = wy_q;
  assign pix.wd        = wd_q;
  assign pix.we        = we_q;
  assign frame_done    = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (frame_start),
    .push      (push),
    .push_data ({pix.res_inset, pix.res_iter}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame FSM, coordinate walk and registered framebuffer write
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    if (frame_start) begin
      state_d = ST_RUN;
      cx_d    = '0;
      cy_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (pop) begin
            we_d = 1'b1;
            wx_d = cx_q;
            wy_d = cy_q;
            wd_d = colour_map(head[7:0], head[8]);
            if (cy_q == 7'(N_PIX_Y - 1)) begin
              cy_d = '0;
              cx_d = (cx_q == 8'(N_PIX_X - 1)) ? 8'd0 : cx_q + 8'd1;
            end else begin
              cy_d = cy_q + 7'd1;
            end
            if (last_pix) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame state and write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
    end
  end

`ifdef ITER_TX_EN
  logic [1:0] tx_state_q, tx_state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;

  // Only release the next pixel once the previous byte has fully gone out
  assign tx_ok    = (tx_state_q == TX_IDLE) && !tx_busy;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  // TX handshake: start pulse, wait for busy to rise, then to fall
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    if (frame_start) begin
      tx_state_d = TX_IDLE;
    end else if (pop) begin
      tx_start_d = 1'b1;
      tx_data_d  = head[7:0];
      tx_state_d = TX_ARM;
    end else begin
      case (tx_state_q)
        TX_ARM:  if (tx_busy)  tx_state_d = TX_WAIT;
        TX_WAIT: if (!tx_busy) tx_state_d = TX_IDLE;
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  // TX sub-FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end
`else
  assign tx_ok = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandel_pixel_writer
// Description : Directed self-checking bench for mandel_pixel_writer.
//               Builds with or without ITER_TX_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mandel_pixel_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  mandel_pixel_writer_if pix();

`ifdef ITER_TX_EN
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       tx_hold = 1'b0;
  int         tx_cnt  = 0;
`endif

  mandel_pixel_writer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .pix         (pix)
`ifdef ITER_TX_EN
    ,
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef ITER_TX_EN
  // UART model: busy for 10 cycles after each start pulse, or forced by tx_hold
  always @(negedge clk) begin
    if (tx_start) begin
      check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
      tx_cnt = 10;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
    end
    tx_busy = tx_hold || (tx_cnt > 0);
  end
`endif

  initial begin
    int pushed, wes, dones, n;
    logic acc;
    logic [7:0] lx, dlx;
    logic [6:0] ly, dly;

    pix.res_valid = 1'b0;
    pix.res_iter  = 8'd0;
    pix.res_inset = 1'b0;
    repeat (2) tick();
    check("rst_we", {31'd0, pix.we}, 0);
    check("rst_wx", {24'd0, pix.wx}, 0);
    check("rst_wy", {25'd0, pix.wy}, 0);
    check("rst_wd", {30'd0, pix.wd}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, pix.res_ready}, 0);
    check("rst_done", {31'd0, frame_done}, 0);
`ifdef ITER_TX_EN
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
`endif
    rst = 1'b0;
    tick();
    pix.res_valid = 1'b1;
    tick();
    check("idle_ready", {31'd0, pix.res_ready}, 0);
    pix.res_valid = 1'b0;

`ifdef ITER_TX_EN
    begin
      logic [1:0] exp_wd [4];
      exp_wd = '{2'd2, 2'd3, 2'd3, 2'd1};
      // Backpressure: TX busy held, valid stuck high
      tx_hold = 1'b1;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      pix.res_valid = 1'b1;
      pushed = 0; wes = 0;
      for (int i = 0; i < 8; i++) begin
        pix.res_iter = 8'(10 + pushed);
        acc = pix.res_ready;
        tick();
        if (acc) pushed++;
        if (pix.we) wes++;
      end
      pix.res_valid = 1'b0;
      check("bp_accepted", pushed, 4);
      check("bp_ready", {31'd0, pix.res_ready}, 0);
      check("bp_no_write", wes, 0);
      tx_hold = 1'b0;
      n = 0;
      for (int c = 0; c < 200 && n < 4; c++) begin
        tick();
        if (pix.we) begin
          check("bp_tx_start", {31'd0, tx_start}, 1);
          check("bp_tx_data", {24'd0, tx_data}, 32'(10 + n));
          check("bp_wx", {24'd0, pix.wx}, 0);
          check("bp_wy", {25'd0, pix.wy}, 32'(n));
          check("bp_wd", {30'd0, pix.wd}, {30'd0, exp_wd[n]});
          n++;
        end
      end
      check("bp_count", n, 4);

      // frame_start with 3 queued entries and a simultaneous push
      tx_hold = 1'b1;
      repeat (2) tick();
      pix.res_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        pix.res_iter = 8'(20 + i);
        tick();
      end
      pix.res_iter = 8'd99;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      pix.res_valid = 1'b0;
      check("fl_we", {31'd0, pix.we}, 0);
      tx_hold = 1'b0;
      wes = 0;
      repeat (30) begin tick(); if (pix.we) wes++; end
      check("fl_empty", wes, 0);
      pix.res_valid = 1'b1; pix.res_iter = 8'd7;
      tick();
      pix.res_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n == 0; c++) begin
        tick();
        if (pix.we) begin
          n = 1;
          check("fl_wx", {24'd0, pix.wx}, 0);
          check("fl_wy", {25'd0, pix.wy}, 0);
          check("fl_wd", {30'd0, pix.wd}, 3);
          check("fl_tx_data", {24'd0, tx_data}, 7);
        end
      end
      check("fl_written", n, 1);
    end
`else
    // First pixels and latency
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("run_busy", {31'd0, busy}, 1);
    check("run_ready", {31'd0, pix.res_ready}, 1);
    pix.res_valid = 1'b1; pix.res_iter = 8'd5;
    tick();
    check("lat_no_we", {31'd0, pix.we}, 0);
    pix.res_iter = 8'd8;
    tick();
    check("p0", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd0, 2'd1});
    pix.res_iter = 8'd3;
    tick();
    check("p1", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd1, 2'd3});
    pix.res_iter = 8'd100; pix.res_inset = 1'b1;
    tick();
    check("p2", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd2, 2'd3});
    pix.res_valid = 1'b0; pix.res_inset = 1'b0;
    tick();
    check("p3", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd3, 2'd0});
    tick();
    check("we_one_cycle", {31'd0, pix.we}, 0);

    // Column wrap: pixels 4..128
    pix.res_valid = 1'b1;
    for (int k = 0; k < 125; k++) begin
      pix.res_iter = 8'(k + 1);
      tick();
      if (k == 124)
        check("col_end", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd127, 2'd3});
    end
    pix.res_valid = 1'b0;
    tick();
    check("col_next", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd1, 1'b0, 7'd0, 2'd1});

    // Rest of the frame
    pushed = 0; wes = 0; dones = 0;
    lx = '0; ly = '0; dlx = '0; dly = '0;
    for (int c = 0; c < 30000; c++) begin
      pix.res_valid = (pushed < 24447);
      pix.res_iter  = 8'(c);
      acc = pix.res_valid && pix.res_ready;
      tick();
      if (acc) pushed++;
      if (pix.we) begin wes++; lx = pix.wx; ly = pix.wy; end
      if (frame_done) begin dones++; dlx = lx; dly = ly; end
      if (pushed == 24447 && !busy) break;
    end
    pix.res_valid = 1'b0;
    check("frame_writes", wes, 24447);
    check("frame_done_count", dones, 1);
    check("frame_done_x", {24'd0, dlx}, 191);
    check("frame_done_y", {25'd0, dly}, 127);
    check("frame_end_busy", {31'd0, busy}, 0);
    pix.res_valid = 1'b1;
    tick();
    check("frame_end_ready", {31'd0, pix.res_ready}, 0);
    pix.res_valid = 1'b0;

    // Reset in the middle of a frame
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix.res_valid = 1'b1; pix.res_iter = 8'd7;
    repeat (11) tick();
    pix.res_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_we", {31'd0, pix.we}, 0);
    check("mid_rst_wxy", {16'd0, pix.wx, 1'b0, pix.wy}, 0);
    check("mid_rst_wd", {30'd0, pix.wd}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_ready", {31'd0, pix.res_ready}, 0);
    dones = 0;
    repeat (3) begin tick(); if (frame_done) dones++; end
    rst = 1'b0;
    repeat (3) begin tick(); if (frame_done) dones++; end
    check("mid_rst_no_done", dones, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix.res_valid = 1'b1; pix.res_iter = 8'd6;
    tick();
    pix.res_valid = 1'b0;
    tick();
    check("restart_p0", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd0, 2'd2});

    // frame_start with a simultaneous push: push dropped, restart at (0,0)
    pix.res_valid = 1'b1; pix.res_iter = 8'd1;
    tick();
    pix.res_iter = 8'd2;
    tick();
    pix.res_iter = 8'd9;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix.res_valid = 1'b0;
    check("fs_clear_we", {31'd0, pix.we}, 0);
    tick();
    check("fs_push_dropped", {31'd0, pix.we}, 0);
    pix.res_valid = 1'b1; pix.res_iter = 8'd4;
    tick();
    pix.res_valid = 1'b0;
    tick();
    check("fs_p0", {pix.we, 14'd0, pix.wx, 1'b0, pix.wy, pix.wd}, {1'b1, 14'd0, 8'd0, 1'b0, 7'd0, 2'd3});
    tick();
    check("fs_idle_after", {31'd0, pix.we}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
